// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for the pixel sensor: erase, expose, ramp-convert onto the shared DATA bus,
// bus turnaround, then read and capture the pixel's stored code.
module pixel_sensor_ctrl #(
    parameter int DATA_W        = 8,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int READ_CYCLES   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_TURN    = 3'd4,
        S_READ    = 3'd5
    } state_t;

    localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] READ_LAST   = 16'(READ_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'((32'd1 << DATA_W) - 32'd1);

    state_t              state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [DATA_W-1:0]   pixel_data_q, pixel_data_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic                busy_q, erase_q, expose_q, convert_q, read_q;
    logic                capture_s;

    // Next-state, phase timer, ramp code and capture decision.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 16'd1;
        capture_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = 16'd0;
                if (start) begin
                    state_d = S_ERASE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERASE: begin
                if (timer_q == ERASE_LAST) begin
                    state_d = S_EXPOSE;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_ERASE;
                end
            end
            S_EXPOSE: begin
                if (timer_q == EXPOSE_LAST) begin
                    state_d = S_CONVERT;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_EXPOSE;
                end
            end
            S_CONVERT: begin
                if (timer_q == CONV_LAST) begin
                    state_d = S_TURN;
                    timer_d = 16'd0;
                end else begin
                    state_d = S_CONVERT;
                end
            end
            S_TURN: begin
                state_d = S_READ;
                timer_d = 16'd0;
            end
            S_READ: begin
                if (timer_q == READ_LAST) begin
                    state_d   = S_IDLE;
                    timer_d   = 16'd0;
                    capture_s = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase

        // Ramp starts at zero on CONVERT entry and otherwise holds its last code.
        if (state_d == S_CONVERT) begin
            if (state_q == S_CONVERT) begin
                data_out_d = data_out_q + DATA_W'(1);
            end else begin
                data_out_d = '0;
            end
        end else begin
            data_out_d = data_out_q;
        end

        if (capture_s) begin
            pixel_data_d = data_in;
        end else begin
            pixel_data_d = pixel_data_q;
        end
        pixel_valid_d = capture_s;
    end

    // State, timer and registered Moore outputs (decoded from the next state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= 16'd0;
            data_out_q    <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            convert_q     <= 1'b0;
            read_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            data_out_q    <= data_out_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= (state_d != S_IDLE);
            erase_q       <= (state_d == S_ERASE);
            expose_q      <= (state_d == S_EXPOSE);
            convert_q     <= (state_d == S_CONVERT);
            read_q        <= (state_d == S_READ);
        end
    end

    assign busy        = busy_q;
    assign erase       = erase_q;
    assign expose      = expose_q;
    assign convert     = convert_q;
    assign data_oe     = convert_q;
    assign read        = read_q;
    assign data_out    = data_out_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Directed bench for pixel_sensor_ctrl: default instance with a ramp-latching pixel model and a
// short-phase instance; frame timing, captured codes, reset abort and phase invariants.
module tb_pixel_sensor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start1;
    logic       busy, erase, expose, convert, read, data_oe, pixel_valid;
    logic [7:0] data_out, data_in, pixel_data;
    logic       busy1, erase1, expose1, convert1, read1, data_oe1, pixel_valid1;
    logic [3:0] data_out1, data_in1, pixel_data1;

    logic [7:0] vstore;
    logic [7:0] pix;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         viol     = 0;

    always #5 clk = ~clk;

    pixel_sensor_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .erase(erase), .expose(expose),
        .convert(convert), .read(read), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .pixel_data(pixel_data), .pixel_valid(pixel_valid)
    );

    pixel_sensor_ctrl #(.DATA_W(4), .ERASE_CYCLES(1), .EXPOSE_CYCLES(3), .READ_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .erase(erase1), .expose(expose1),
        .convert(convert1), .read(read1), .data_out(data_out1), .data_oe(data_oe1),
        .data_in(data_in1), .pixel_data(pixel_data1), .pixel_valid(pixel_valid1)
    );

    // Pixel keeps following the ramp until the code exceeds vstore, so it holds vstore.
    always @(posedge clk) begin
        if (convert && !(data_out > vstore)) pix <= data_out;
    end

    assign data_in  = data_oe ? data_out : (read ? pix : 8'h5A);
    assign data_in1 = read1 ? 4'hC : 4'h3;

    always @(negedge clk) begin
        if (!reset) begin
            if (!$onehot0({erase, expose, convert, read}))     viol++;
            if (data_oe && read)                               viol++;
            if (data_oe != convert)                            viol++;
            if ((erase | expose | convert | read) && !busy)    viol++;
            if (!$onehot0({erase1, expose1, convert1, read1})) viol++;
            if (data_oe1 && read1)                             viol++;
            if (data_oe1 != convert1)                          viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame from start sampled to the pixel_valid cycle; leaves the bench in that cycle.
    task automatic run_frame(input logic [7:0] vs, input logic [7:0] exp_pix, input bit hold,
                             input string tag);
        int n_er = 0, n_ex = 0, n_cv = 0, n_tu = 0, n_rd = 0;
        int ramp_bad = 0, turn_bad = 0, cyc = 0;
        vstore = vs;
        start  = 1'b1;
        step();
        if (!hold) start = 1'b0;
        while (!pixel_valid && cyc < 2000) begin
            if (erase)  n_er++;
            if (expose) n_ex++;
            if (convert) begin
                if (data_out != n_cv[7:0]) ramp_bad++;
                n_cv++;
            end
            if (busy && !erase && !expose && !convert && !read) begin
                n_tu++;
                if (data_out != 8'hFF || data_oe) turn_bad++;
            end
            if (read) n_rd++;
            step();
            cyc++;
        end
        chk({tag, " frame_len"},  cyc,        522);
        chk({tag, " erase_len"},  n_er,       5);
        chk({tag, " expose_len"}, n_ex,       255);
        chk({tag, " conv_len"},   n_cv,       256);
        chk({tag, " ramp_codes"}, ramp_bad,   0);
        chk({tag, " turn_len"},   n_tu,       1);
        chk({tag, " turn_bus"},   turn_bad,   0);
        chk({tag, " read_len"},   n_rd,       5);
        chk({tag, " pixel_data"}, pixel_data, exp_pix);
        chk({tag, " idle_busy"},  busy,       0);
    endtask

    typedef struct {
        logic [7:0] vs;
        logic [7:0] exp;
        bit         hold;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   cnt;
        int   act;
        int   n_er1, n_rd1;

        tbl[0] = '{vs: 8'd100, exp: 8'd100, hold: 1'b0};
        tbl[1] = '{vs: 8'd0,   exp: 8'd0,   hold: 1'b0};
        tbl[2] = '{vs: 8'd255, exp: 8'd255, hold: 1'b0};
        tbl[3] = '{vs: 8'd100, exp: 8'd100, hold: 1'b1};
        tbl[4] = '{vs: 8'd42,  exp: 8'd42,  hold: 1'b0};

        reset = 1'b1; start = 1'b0; start1 = 1'b0; vstore = 8'd0; pix = 8'd0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_ctrl", {busy, erase, expose, convert, read, data_oe, pixel_valid}, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_pixel_data", pixel_data, 0);
        chk("reset_dut1", {busy1, erase1, read1, data_oe1, pixel_valid1, pixel_data1}, 0);

        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || erase || expose || convert || read || data_oe || pixel_valid) act++;
            step();
        end
        chk("idle_no_activity", act, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].vs, tbl[i].exp, tbl[i].hold, $sformatf("vec%0d", i));
        end
        step();
        chk("valid_one_cycle", pixel_valid, 0);
        chk("no_requeue", busy, 0);

        // Abort mid-convert at code 37.
        vstore = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (!(convert && data_out == 8'd37) && cnt < 1000) begin
            step();
            cnt++;
        end
        chk("reach_code37", {convert, data_out}, {1'b1, 8'd37});
        reset = 1'b1;
        #1;
        chk("abort_data_oe", data_oe, 0);
        chk("abort_data_out", data_out, 0);
        chk("abort_busy", {busy, convert}, 0);
        step();
        step();
        reset = 1'b0;
        act = 0;
        for (int i = 0; i < 600; i++) begin
            if (pixel_valid || busy) act++;
            step();
        end
        chk("abort_no_valid", act, 0);
        run_frame(8'd200, 8'd200, 1'b0, "restart");

        // Short-phase instance.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        cnt = 0; n_er1 = 0; n_rd1 = 0;
        while (!pixel_valid1 && cnt < 200) begin
            if (erase1) n_er1++;
            if (read1)  n_rd1++;
            step();
            cnt++;
        end
        chk("short_frame_len", cnt, 22);
        chk("short_erase_len", n_er1, 1);
        chk("short_read_len", n_rd1, 1);
        chk("short_pixel_data", pixel_data1, 4'hC);

        step();
        chk("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
